// File: rtl/bus_mem_responder.sv
// Single-port word memory answering load/store requests on the datapath bus,
// with programmable wait states and a preload port for boot/bench initialisation.
module bus_mem_responder #(
   parameter int          AW   = 10,
   parameter logic [31:0] BASE = 32'h0,
   parameter int          WAIT = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   addr,
   input  logic [2:0]    size,
   input  logic          valid,
   input  logic          write,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          ready,
   output logic          err,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data,
   output logic          ld_busy
);

   // Handshake: valid is held by the initiator until it sees ready; ready is a
   // single-cycle pulse issued only in RESP, followed by one DONE cycle so a
   // still-high valid is never taken as a second request.
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

   localparam logic [3:0] WAIT_M1   = 4'(WAIT - 1);
   localparam logic       WAIT_ZERO = (WAIT == 0);

   state_t        state;
   logic [3:0]    cnt;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [2:0]    req_size;
   logic          req_write;
   logic [31:0]   mem [2**AW];

   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [2:0]    cur_size;
   logic          cur_write;
   logic [31:0]   off;
   logic [1:0]    lane;
   logic [AW-1:0] idx;
   logic          cur_err;
   logic [3:0]    be;
   logic [31:0]   wr_shift;
   logic          enter_resp;
   logic          st_we;
   logic          ld_acc;
   logic          unused_off;

   // In IDLE the live bus inputs are used so a zero-wait access commits at the
   // accepting edge; later states use the latched copy.
   always_comb begin
      cur_addr   = (state == S_IDLE) ? addr  : req_addr;
      cur_wdata  = (state == S_IDLE) ? wdata : req_wdata;
      cur_size   = (state == S_IDLE) ? size  : req_size;
      cur_write  = (state == S_IDLE) ? write : req_write;
      off        = cur_addr - BASE;
      lane       = cur_addr[1:0];
      idx        = off[AW+1:2];
      cur_err    = (off[31:AW+2] != '0);
      be         = 4'h0;
      case (cur_size)
         3'd0: be = 4'b0001 << lane;
         3'd1: begin
            be = 4'b0011 << lane;
            if (lane[0]) cur_err = 1'b1;
         end
         3'd2: begin
            be = 4'hF;
            if (lane != 2'd0) cur_err = 1'b1;
         end
         default: cur_err = 1'b1;
      endcase
      wr_shift   = cur_wdata << {lane, 3'b000};
      enter_resp = (state == S_IDLE && valid && WAIT_ZERO) ||
                   (state == S_WAIT && cnt == '0);
      st_we      = enter_resp && cur_write && !cur_err && !rst;
      ld_acc     = ld_en && state == S_IDLE && !valid;
   end

   assign ld_busy    = !(state == S_IDLE && !valid);
   assign unused_off = ^off[1:0];

   // Bus stores and preloads never coincide, so this maps to one RAM write port.
   always_ff @(posedge clk) begin
      if (st_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
         end
      end else if (ld_acc) begin
         mem[ld_addr] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_IDLE: if (valid) begin
               req_addr  <= addr;
               req_wdata <= wdata;
               req_size  <= size;
               req_write <= write;
               cnt       <= WAIT_M1;
               state     <= WAIT_ZERO ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == '0) state <= S_RESP;
            end
            S_RESP:  state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         if (enter_resp) begin
            ready <= 1'b1;
            err   <= cur_err;
            if (!cur_write) rdata <= cur_err ? '0 : mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench: a zero-wait and a three-wait responder share the bus inputs,
// a vector table drives the zero-wait one, hand sequences cover multi-cycle cases.
module tb_bus_mem_responder;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   addr;
   logic [2:0]    size;
   logic          write;
   logic [31:0]   wdata;
   logic          valid0, valid3;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_data;
   logic [31:0]   rdata0, rdata3;
   logic          ready0, ready3, err0, err3, ld_busy0, ld_busy3;

   int errors  = 0;
   int checks  = 0;
   int pulses3 = 0;

   typedef struct {
      int          op;       // 0 = bus access, 1 = preload (ad = word index)
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] ad;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[22];

   always #5 clk = ~clk;

   bus_mem_responder #(.AW(AW), .BASE(32'h0), .WAIT(0)) u0 (
      .clk(clk), .rst(rst), .addr(addr), .size(size), .valid(valid0),
      .write(write), .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy0)
   );

   bus_mem_responder #(.AW(AW), .BASE(32'h0), .WAIT(3)) u3 (
      .clk(clk), .rst(rst), .addr(addr), .size(size), .valid(valid3),
      .write(write), .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy3)
   );

   always @(negedge clk) if (ready3 === 1'b1) pulses3++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      #1;
      check("preload_busy0", {31'b0, ld_busy0}, 32'd0);
      check("preload_busy3", {31'b0, ld_busy3}, 32'd0);
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic bus_req(input int sel, input logic wr, input logic [2:0] sz,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
      logic rdy;
      @(negedge clk);
      addr  = ad;
      size  = sz;
      write = wr;
      wdata = wd;
      if (sel == 0) valid0 = 1'b1; else valid3 = 1'b1;
      lat = 0;
      rd  = '0;
      er  = 1'b0;
      rdy = 1'b0;
      while (lat < 40 && !rdy) begin
         @(negedge clk);
         lat++;
         rdy = (sel == 0) ? ready0 : ready3;
      end
      rd     = (sel == 0) ? rdata0 : rdata3;
      er     = (sel == 0) ? err0 : err3;
      valid0 = 1'b0;
      valid3 = 1'b0;
      @(negedge clk);
      rdy = (sel == 0) ? ready0 : ready3;
      check("ready_pulse_width", {31'b0, rdy}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          p0;

      vecs[0]  = '{0, 1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{0, 1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1, 1'b0, 3'd0, 32'h4,    32'h11223344, 32'h0,        1'b0};
      vecs[3]  = '{0, 1'b1, 3'd0, 32'h12,   32'h000000AB, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{0, 1'b0, 3'd2, 32'h10,   32'h0,        32'h11AB3344, 1'b0};
      vecs[5]  = '{0, 1'b0, 3'd0, 32'h12,   32'h0,        32'h11AB3344, 1'b0};
      vecs[6]  = '{1, 1'b0, 3'd0, 32'h5,    32'h0,        32'h0,        1'b0};
      vecs[7]  = '{0, 1'b1, 3'd1, 32'h16,   32'h0000CAFE, 32'h11AB3344, 1'b0};
      vecs[8]  = '{0, 1'b0, 3'd2, 32'h14,   32'h0,        32'hCAFE0000, 1'b0};
      vecs[9]  = '{0, 1'b0, 3'd1, 32'h15,   32'h0,        32'h00000000, 1'b1};
      vecs[10] = '{0, 1'b0, 3'd2, 32'h14,   32'h0,        32'hCAFE0000, 1'b0};
      vecs[11] = '{0, 1'b1, 3'd2, 32'h13,   32'hFFFFFFFF, 32'hCAFE0000, 1'b1};
      vecs[12] = '{0, 1'b0, 3'd2, 32'h10,   32'h0,        32'h11AB3344, 1'b0};
      vecs[13] = '{0, 1'b0, 3'd3, 32'h10,   32'h0,        32'h00000000, 1'b1};
      vecs[14] = '{0, 1'b0, 3'd2, 32'h1000, 32'h0,        32'h00000000, 1'b1};
      vecs[15] = '{0, 1'b1, 3'd2, 32'hFFC,  32'hA5A50F0F, 32'h00000000, 1'b0};
      vecs[16] = '{0, 1'b0, 3'd2, 32'hFFC,  32'h0,        32'hA5A50F0F, 1'b0};
      vecs[17] = '{0, 1'b1, 3'd0, 32'h17,   32'h000000FF, 32'hA5A50F0F, 1'b0};
      vecs[18] = '{0, 1'b1, 3'd1, 32'h14,   32'h1234ABCD, 32'hA5A50F0F, 1'b0};
      vecs[19] = '{0, 1'b0, 3'd2, 32'h14,   32'h0,        32'hFFFEABCD, 1'b0};
      vecs[20] = '{0, 1'b1, 3'd2, 32'h1010, 32'h0,        32'hFFFEABCD, 1'b1};
      vecs[21] = '{0, 1'b0, 3'd2, 32'h10,   32'h0,        32'h11AB3344, 1'b0};

      // Clock and reset
      rst = 1'b1; valid0 = 1'b0; valid3 = 1'b0; ld_en = 1'b0;
      addr = '0; size = '0; write = 1'b0; wdata = '0; ld_addr = '0; ld_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ready", {31'b0, ready0}, 32'd0);
      check("reset_err", {31'b0, err0}, 32'd0);
      check("reset_rdata", rdata0, 32'd0);
      check("reset_ld_busy", {31'b0, ld_busy0}, 32'd0);

      // Zero-wait vector table
      for (int i = 0; i < 22; i++) begin
         if (vecs[i].op == 1) begin
            preload(vecs[i].ad[AW-1:0], vecs[i].wd);
         end else begin
            bus_req(0, vecs[i].wr, vecs[i].sz, vecs[i].ad, vecs[i].wd, rd, er, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
         end
      end

      // WAIT=3, ten requests with valid held high throughout
      @(negedge clk);
      p0     = pulses3;
      valid3 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         write = (i < 5);
         size  = 3'd2;
         addr  = 32'h40 + 32'(4 * (i % 5));
         wdata = 32'hA0000000 + 32'(i);
         lat   = 0;
         while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready3) break;
         end
         check($sformatf("b2b%0d_latency", i), 32'(lat), (i == 0) ? 32'd4 : 32'd6);
         check($sformatf("b2b%0d_err", i), {31'b0, err3}, 32'd0);
         if (i >= 5) check($sformatf("b2b%0d_rdata", i), rdata3, 32'hA0000000 + 32'(i - 5));
      end
      valid3 = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b_ready_pulses", 32'(pulses3 - p0), 32'd10);

      // Reset lands on the commit edge of a waited store
      preload(8, 32'h12345678);
      @(negedge clk);
      addr = 32'h20; size = 3'd2; write = 1'b1; wdata = 32'h55; valid3 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_wait_ready", {31'b0, ready3}, 32'd0);
      check("rst_wait_rdata", rdata3, 32'd0);
      rst = 1'b0; valid3 = 1'b0;
      @(negedge clk);
      check("rst_wait_ready_after", {31'b0, ready3}, 32'd0);
      bus_req(3, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
      check("rst_reload_latency", 32'(lat), 32'd4);
      check("rst_reload_rdata", rd, 32'h12345678);
      check("rst_reload_err", {31'b0, er}, 32'd0);

      // valid dropped while waiting: the access still completes
      @(negedge clk);
      addr = 32'h44; size = 3'd2; write = 1'b0; valid3 = 1'b1;
      @(negedge clk);
      valid3 = 1'b0;
      lat = 1;
      while (lat < 40 && !ready3) begin
         @(negedge clk);
         lat++;
      end
      check("drop_valid_latency", 32'(lat), 32'd4);
      check("drop_valid_rdata", rdata3, 32'hA0000001);
      repeat (2) @(negedge clk);

      // Preload colliding with a bus request is refused
      preload(12, 32'h0);
      @(negedge clk);
      addr = 32'h30; size = 3'd2; write = 1'b0; valid0 = 1'b1;
      ld_en = 1'b1; ld_addr = 12; ld_data = 32'h9ABC0123;
      #1;
      check("collide_ld_busy", {31'b0, ld_busy0}, 32'd1);
      @(negedge clk);
      ld_en = 1'b0;
      check("collide_ready", {31'b0, ready0}, 32'd1);
      check("collide_rdata", rdata0, 32'd0);
      valid0 = 1'b0;
      @(negedge clk);
      bus_req(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat);
      check("collide_dropped", rd, 32'd0);
      preload(12, 32'h9ABC0123);
      bus_req(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat);
      check("retry_rdata", rd, 32'h9ABC0123);
      check("retry_err", {31'b0, er}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
